// File: rtl/shift_arb_32.sv
// Two-port round-robin front end sharing one 32-bit barrel shifter, with a
// single-entry registered response slot and an accepted-request counter.

module bshift_32 (
   input  logic [31:0] a_i,
   input  logic [4:0]  b_i,
   input  logic [2:0]  op_i,
   output logic [31:0] q_o,
   output logic        ov_o,
   output logic        z_o
);

   logic        rot;
   logic        left;
   logic        arith;
   logic        fill;
   logic [31:0] stg [0:5];
   logic [31:0] back_a;

   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   assign rot   = op_i[2];
   assign left  = op_i[1];
   assign arith = op_i[0];

   // Left operations run through the right-shift stages on bit-reversed data.
   assign fill   = arith & ~left & ~rot & a_i[31];
   assign stg[0] = left ? bit_rev(a_i) : a_i;

   for (genvar k = 0; k < 5; k++) begin : g_stage
      localparam int SH = 1 << k;
      logic [31:0] shifted;
      assign shifted    = rot ? {stg[k][SH-1:0], stg[k][31:SH]}
                              : {{SH{fill}}, stg[k][31:SH]};
      assign stg[k+1]   = b_i[k] ? shifted : stg[k];
   end

   assign q_o = left ? bit_rev(stg[5]) : stg[5];

   // A left shift overflows when shifting the result back cannot recover the operand.
   assign back_a = arith ? 32'($signed(q_o) >>> b_i) : (q_o >> b_i);
   assign ov_o   = left & ~rot & (back_a != a_i);
   assign z_o    = (q_o == 32'd0);

endmodule

module shift_arb_32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req1_a,
   input  logic [4:0]  req0_b,
   input  logic [4:0]  req1_b,
   input  logic [2:0]  req0_op,
   input  logic [2:0]  req1_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_q,
   output logic        rsp_ov,
   output logic        rsp_z,
   output logic [15:0] op_count
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Handshake: a request transfers on a cycle where req_valid[i] and
   // req_ready[i] are both high; a response transfers when rsp_valid and
   // rsp_ready are both high. The response slot holds its value until taken.

   logic [0:0]  state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_q_q, rsp_q_d;
   logic        rsp_ov_q, rsp_ov_d;
   logic        rsp_z_q, rsp_z_d;
   logic [15:0] count_q, count_d;

   logic        slot_free;
   logic [1:0]  grant;
   logic        accept;
   logic        acc_id;
   logic [31:0] sh_a;
   logic [4:0]  sh_b;
   logic [2:0]  sh_op;
   logic [31:0] sh_q;
   logic        sh_ov;
   logic        sh_z;

   assign rsp_valid = (state_q == ST_FULL);
   assign slot_free = ~rsp_valid | rsp_ready;

   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready = grant & {2{slot_free}};
   assign accept    = |(req_valid & req_ready);
   assign acc_id    = req_ready[1];

   // Operands are muxed only on an accept so the shifter sits at zero otherwise.
   always_comb begin
      sh_a  = 32'd0;
      sh_b  = 5'd0;
      sh_op = 3'd0;
      if (req_ready[0]) begin
         sh_a  = req0_a;
         sh_b  = req0_b;
         sh_op = req0_op;
      end else if (req_ready[1]) begin
         sh_a  = req1_a;
         sh_b  = req1_b;
         sh_op = req1_op;
      end
   end

   bshift_32 u_shift (
      .a_i  (sh_a),
      .b_i  (sh_b),
      .op_i (sh_op),
      .q_o  (sh_q),
      .ov_o (sh_ov),
      .z_o  (sh_z)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rsp_id_d     = rsp_id_q;
      rsp_q_d      = rsp_q_q;
      rsp_ov_d     = rsp_ov_q;
      rsp_z_d      = rsp_z_q;
      count_d      = count_q;
      if (accept) begin
         state_d      = ST_FULL;
         last_grant_d = acc_id;
         rsp_id_d     = acc_id;
         rsp_q_d      = sh_q;
         rsp_ov_d     = sh_ov;
         rsp_z_d      = sh_z;
         count_d      = count_q + 16'd1;
      end else if (state_q == ST_FULL && rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_q_q      <= 32'd0;
         rsp_ov_q     <= 1'b0;
         rsp_z_q      <= 1'b0;
         count_q      <= 16'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_id_q     <= rsp_id_d;
         rsp_q_q      <= rsp_q_d;
         rsp_ov_q     <= rsp_ov_d;
         rsp_z_q      <= rsp_z_d;
         count_q      <= count_d;
      end
   end

   assign rsp_id   = rsp_id_q;
   assign rsp_q    = rsp_q_q;
   assign rsp_ov   = rsp_ov_q;
   assign rsp_z    = rsp_z_q;
   assign op_count = count_q;

endmodule

// File: tb/tb_shift_arb_32.sv
// Directed bench for shift_arb_32: arbitration, shifter results, flags,
// back-pressure, reset while full and counter wrap.

module tb_shift_arb_32;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req0_a, req1_a;
   logic [4:0]  req0_b, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_q;
   logic        rsp_ov;
   logic        rsp_z;
   logic [15:0] op_count;

   int checks;
   int errors;

   // {valid, id, ov, z, q}
   logic [35:0] got;
   logic [35:0] exp;

   shift_arb_32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req0_a    (req0_a),
      .req1_a    (req1_a),
      .req0_b    (req0_b),
      .req1_b    (req1_b),
      .req0_op   (req0_op),
      .req1_op   (req1_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_q     (rsp_q),
      .rsp_ov    (rsp_ov),
      .rsp_z     (rsp_z),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign got = {rsp_valid, rsp_id, rsp_ov, rsp_z, rsp_q};

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      req0_a = 32'd0; req0_b = 5'd0; req0_op = 3'd0;
      req1_a = 32'd0; req1_b = 5'd0; req1_op = 3'd0;
      #2;
      checks++;
      if (got !== 36'd0) begin
         errors++;
         $display("FAIL reset_rsp: got %h expected %h", got, 36'd0);
      end
      checks++;
      if (op_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %h expected 0000", op_count);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_rotate();
      req_valid = 2'b01; rsp_ready = 1'b1;
      req0_a = 32'h8000_0001; req0_b = 5'd1; req0_op = 3'b100;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rot_ready: got %b expected 01", req_ready);
      end
      next_cycle();
      req_valid = 2'b00;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'hC000_0000};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL rot_rsp: got %h expected %h", got, exp);
      end
      next_cycle();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rot_drain: got %b expected 0", rsp_valid);
      end
   endtask

   task automatic load_tie_operands();
      req0_a = 32'h8000_0000; req0_b = 5'd4;  req0_op = 3'b001;
      req1_a = 32'h0000_0001; req1_b = 5'd31; req1_op = 3'b010;
   endtask

   task automatic test_tie();
      test_reset();
      load_tie_operands();
      req_valid = 2'b11; rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL tie_first_grant: got %b expected 01", req_ready);
      end
      next_cycle();
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'hF800_0000};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL tie_sra: got %h expected %h", got, exp);
      end
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL tie_second_grant: got %b expected 10", req_ready);
      end
      next_cycle();
      req_valid = 2'b00;
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL tie_sll: got %h expected %h", got, exp);
      end
      checks++;
      if (op_count !== 16'd2) begin
         errors++;
         $display("FAIL tie_count: got %0d expected 2", op_count);
      end
      next_cycle();
   endtask

   task automatic test_flags();
      req1_a = 32'h4000_0000; req1_b = 5'd1; req1_op = 3'b011;
      req_valid = 2'b10; rsp_ready = 1'b1;
      next_cycle();
      exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0000};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL flag_sla_ov: got %h expected %h", got, exp);
      end
      req0_a = 32'h0000_000F; req0_b = 5'd4; req0_op = 3'b000;
      req_valid = 2'b01;
      next_cycle();
      req_valid = 2'b00;
      exp = {1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL flag_srl_z: got %h expected %h", got, exp);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [35:0] held;
      test_reset();
      load_tie_operands();
      req_valid = 2'b11; rsp_ready = 1'b0;
      next_cycle();
      held = {1'b1, 1'b0, 1'b0, 1'b0, 32'hF800_0000};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got !== held || req_ready !== 2'b00 || op_count !== 16'd1) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got rsp %h ready %b count %0d expected rsp %h ready 00 count 1",
                     i, got, req_ready, op_count, held);
         end
         next_cycle();
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (req_ready !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL release_grant[%0d]: got %b", i, req_ready);
         end
         next_cycle();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== ((i % 2 == 0) ? 1'b1 : 1'b0)
             || op_count !== 16'(i + 2)) begin
            errors++;
            $display("FAIL release_rsp[%0d]: got valid %b id %b count %0d expected id %0d count %0d",
                     i, rsp_valid, rsp_id, op_count, (i % 2 == 0) ? 1 : 0, i + 2);
         end
      end
   endtask

   task automatic test_reset_full();
      rsp_ready = 1'b0;
      next_cycle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== 16'd0 || rsp_q !== 32'd0) begin
         errors++;
         $display("FAIL reset_full: got valid %b count %0d q %h expected 0 0 0",
                  rsp_valid, op_count, rsp_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL post_reset_tie: got %b expected 01", req_ready);
      end
      next_cycle();
      req_valid = 2'b00;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || op_count !== 16'd1) begin
         errors++;
         $display("FAIL post_reset_rsp: got valid %b id %b count %0d expected 1 0 1",
                  rsp_valid, rsp_id, op_count);
      end
      next_cycle();
   endtask

   task automatic test_wrap();
      test_reset();
      req0_a = 32'h1; req0_b = 5'd0; req0_op = 3'b000;
      req_valid = 2'b01; rsp_ready = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      checks++;
      if (op_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL count_max: got %h expected ffff", op_count);
      end
      next_cycle();
      req_valid = 2'b00;
      checks++;
      if (op_count !== 16'h0000) begin
         errors++;
         $display("FAIL count_wrap: got %h expected 0000", op_count);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_rotate();
      test_tie();
      test_flags();
      test_back_to_back();
      test_reset_full();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_arb_32.md
SHIFT_ARB_32 -- requirements
Module: shift_arb_32

Interface
REQ-001 The block SHALL have these parameters: none; operand width fixed at 32, shift amount width fixed at 5.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-port request valid, bit i = port i.
REQ-005 req_ready  output  2  per-port request accept, bit i = port i.
REQ-006 req0_a, req1_a  input  32 each  operand to shift.
REQ-007 req0_b, req1_b  input  5 each  shift/rotate amount.
REQ-008 req0_op, req1_op  input  3 each  {rotate, left, arith} controls, passed to the shifter unmodified.
REQ-009 rsp_valid  output  1  held result valid.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  port that issued the held result.
REQ-012 rsp_q  output  32  held shift result.
REQ-013 rsp_ov, rsp_z  output  1 each  held overflow and zero flags.
REQ-014 op_count  output  16  count of accepted requests.

Function
REQ-015 The block SHALL contain exactly one bshift_32 instance, shared by both ports.
REQ-016 slot_free = ~rsp_valid | rsp_ready, evaluated combinationally.
REQ-017 Arbitration is combinational round-robin:
- one port valid -> that port granted;
- both ports valid -> the port not in last_grant granted;
- none valid -> no grant.
REQ-018 req_ready[i] = grant[i] & slot_free.
- At most one req_ready bit is high in any cycle.
- req_ready does not depend on req_valid of the other port beyond arbitration.
REQ-019 Accept = req_valid[i] & req_ready[i]. On accept, the shifter is driven from port i operands in the same cycle. At the next edge: rsp_q/rsp_ov/rsp_z <= shifter q/ov/z, rsp_id <= i, rsp_valid <= 1, last_grant <= i.
REQ-020 Latency SHALL be one cycle, accept edge to rsp_valid high. With a continuous rsp_ready and requests always pending, throughput SHALL be one result per cycle.
REQ-021 Response state machine:
- EMPTY (rsp_valid=0):
  - accept -> FULL;
  - no accept -> stay EMPTY.
- FULL (rsp_valid=1):
  - rsp_ready with accept -> FULL, reloaded with the new result;
  - rsp_ready without accept -> EMPTY;
  - no rsp_ready -> FULL, all rsp_* held stable.
REQ-022 While FULL and rsp_ready=0, req_ready SHALL be 0 on both ports and last_grant SHALL NOT change.
REQ-023 The shifter inputs SHALL be driven to zero when no port is granted, so they do not toggle.
REQ-024 op_count SHALL increment by 1 on each accept and wrap from 0xFFFF to 0x0000.
REQ-025 A requester that drops req_valid without an accept causes no state change.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold, independent of clk:
- rsp_valid=0, rsp_id=0, rsp_q=0, rsp_ov=0, rsp_z=0;
- op_count=0;
- last_grant=1, so port 0 wins the first tie.
REQ-027 Reset asserted while FULL SHALL discard the held result with no response delivered. The first accept after rst_n rises SHALL behave as from EMPTY.

Verification
REQ-028 Port0 only, a=0x80000001, b=1, op=rotate right (100), rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_q=0xC0000000.
REQ-029 Both ports valid after reset, port0 a=0x80000000 b=4 op=001 (sra), port1 a=0x00000001 b=31 op=010 (sll) -> first accept is port0 with rsp_q=0xF8000000. Next accept is port1 with rsp_q=0x80000000. op_count=2.
REQ-030 Port1 a=0x40000000 b=1 op=011 (sla) -> rsp_ov=1. Port0 a=0x0000000F b=4 op=000 (srl) -> rsp_q=0, rsp_z=1.
REQ-031 Hold rsp_ready=0 for 5 cycles with both ports valid -> all rsp_* stable, req_ready=00, op_count unchanged. Release rsp_ready -> one accept per cycle, ports alternating.
REQ-032 Assert rst_n=0 while FULL -> rsp_valid low immediately, op_count=0. After release, a tie is granted to port 0.
